// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elevator_pkg
// Description : Types and default sizing shared between the request scheduler
//               and the car controller so floor-index widths always agree.
// Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

  // Default building size; the car controller sizes next_floor from these.
  localparam int c_num_floors = 6;
  localparam int c_floor_w    = 3;

  // Sweep direction of the collective (SCAN) scheduler.
  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_e;

endpackage : elevator_pkg
`default_nettype wire

// File: rtl/elevator_floor_search.sv
`default_nettype none
// ============================================================================
// Module      : elevator_floor_search
// Description : Combinational search on one side of the car (strictly above
//               or strictly below current_floor). Reports the sweep target
//               (nearest floor in req_near, else the farthest floor in
//               req_far), the nearest floor holding any request, and whether
//               any request exists on that side at all.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_floor_search
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = c_num_floors,
  parameter int FLOOR_W    = c_floor_w
) (
  input  logic [NUM_FLOORS-1:0] req_near,
  input  logic [NUM_FLOORS-1:0] req_far,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  search_up,
  output logic [FLOOR_W-1:0]    sweep_floor,
  output logic [FLOOR_W-1:0]    nearest_floor,
  output logic                  found
);

  logic [NUM_FLOORS-1:0] w_range;
  logic [NUM_FLOORS-1:0] w_req_any;
  logic                  w_near_hit;
  logic [FLOOR_W-1:0]    w_near_floor;
  logic                  w_far_hit;
  logic [FLOOR_W-1:0]    w_far_floor;
  logic                  w_any_hit;
  logic [FLOOR_W-1:0]    w_any_floor;

  assign w_req_any = req_near | req_far;

  // Floors strictly on the searched side of the car.
  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_range
    assign w_range[i] = search_up ? (FLOOR_W'(i) > current_floor)
                                  : (FLOOR_W'(i) < current_floor);
  end

  // Ascending scan: "nearest" keeps the first hit going up and the last hit
  // going down; "farthest" does the opposite.
  always_comb begin
    w_near_hit   = 1'b0;
    w_near_floor = '0;
    w_far_hit    = 1'b0;
    w_far_floor  = '0;
    w_any_hit    = 1'b0;
    w_any_floor  = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (w_range[i] && req_near[i] && (!search_up || !w_near_hit)) begin
        w_near_floor = FLOOR_W'(i);
        w_near_hit   = 1'b1;
      end
      if (w_range[i] && req_far[i] && (search_up || !w_far_hit)) begin
        w_far_floor = FLOOR_W'(i);
        w_far_hit   = 1'b1;
      end
      if (w_range[i] && w_req_any[i] && (!search_up || !w_any_hit)) begin
        w_any_floor = FLOOR_W'(i);
        w_any_hit   = 1'b1;
      end
    end
  end

  // Same-direction requests take priority; opposite-direction hall calls are
  // served from the far end so the sweep turns around there.
  always_comb begin
    sweep_floor   = w_near_hit ? w_near_floor : w_far_floor;
    nearest_floor = w_any_floor;
    found         = w_any_hit;
  end

endmodule : elevator_floor_search
`default_nettype wire

// File: rtl/elevator_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : elevator_request_scheduler
// Description : Latches car/hall buttons into pending-request registers,
//               clears them on service, and runs a SCAN direction FSM that
//               presents the next target floor to the car controller.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = c_num_floors,
  parameter int FLOOR_W    = c_floor_w
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] btn_car,
  input  logic [NUM_FLOORS-1:0] btn_hall_up,
  input  logic [NUM_FLOORS-1:0] btn_hall_down,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  serviced,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  target_valid,
  output logic [1:0]            direction,
  output logic [NUM_FLOORS-1:0] pend_car,
  output logic [NUM_FLOORS-1:0] pend_up,
  output logic [NUM_FLOORS-1:0] pend_down
);

  // No up call exists at the top floor and no down call at the ground floor.
  localparam logic [NUM_FLOORS-1:0] c_up_mask   = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] c_down_mask = {{(NUM_FLOORS-1){1'b1}}, 1'b0};
  localparam logic [FLOOR_W:0]      c_num       = (FLOOR_W+1)'(NUM_FLOORS);

  logic [NUM_FLOORS-1:0] r_pend_car, r_pend_up, r_pend_down;
  logic [NUM_FLOORS-1:0] w_car_nxt, w_up_nxt, w_down_nxt;
  logic [NUM_FLOORS-1:0] w_clr_car, w_clr_up, w_clr_down;
  logic [NUM_FLOORS-1:0] w_req_all, w_cur_onehot, w_above, w_below;
  logic                  w_legal, w_any_above, w_any_below, w_req_here;

  dir_e                  r_direction, w_dir_nxt;
  logic [FLOOR_W-1:0]    r_target, w_target_nxt;
  logic                  r_valid, w_valid_nxt;

  logic [FLOOR_W-1:0]    w_up_sweep, w_up_near, w_dn_sweep, w_dn_near;
  logic                  w_up_found, w_dn_found;
  logic [FLOOR_W-1:0]    w_dist_up, w_dist_dn;

  assign w_legal   = {1'b0, current_floor} < c_num;
  assign w_req_all = r_pend_car | r_pend_up | r_pend_down;

  // Per-floor position of each floor relative to the car.
  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_floor_pos
    assign w_cur_onehot[i] = w_legal && (current_floor == FLOOR_W'(i));
    assign w_above[i]      = FLOOR_W'(i) > current_floor;
    assign w_below[i]      = FLOOR_W'(i) < current_floor;
  end

  assign w_any_above = |(w_req_all & w_above);
  assign w_any_below = |(w_req_all & w_below);
  assign w_req_here  = |(w_req_all & w_cur_onehot);

  // Sweep-up view: car/up calls first, down calls as the turnaround point.
  elevator_floor_search #(
    .NUM_FLOORS(NUM_FLOORS),
    .FLOOR_W   (FLOOR_W)
  ) u_search_above (
    .req_near     (r_pend_car | r_pend_up),
    .req_far      (r_pend_down),
    .current_floor(current_floor),
    .search_up    (1'b1),
    .sweep_floor  (w_up_sweep),
    .nearest_floor(w_up_near),
    .found        (w_up_found)
  );

  // Sweep-down view: car/down calls first, up calls as the turnaround point.
  elevator_floor_search #(
    .NUM_FLOORS(NUM_FLOORS),
    .FLOOR_W   (FLOOR_W)
  ) u_search_below (
    .req_near     (r_pend_car | r_pend_down),
    .req_far      (r_pend_up),
    .current_floor(current_floor),
    .search_up    (1'b0),
    .sweep_floor  (w_dn_sweep),
    .nearest_floor(w_dn_near),
    .found        (w_dn_found)
  );

  assign w_dist_up = w_up_near - current_floor;
  assign w_dist_dn = current_floor - w_dn_near;

  // Service clears: the hall call matching the travel direction is answered;
  // the opposite one only when the car is about to reverse here.
  always_comb begin
    w_clr_car  = '0;
    w_clr_up   = '0;
    w_clr_down = '0;
    if (serviced) begin
      w_clr_car = w_cur_onehot;
      case (r_direction)
        DIR_UP: begin
          w_clr_up = w_cur_onehot;
          if (!w_any_above) w_clr_down = w_cur_onehot;
        end
        DIR_DOWN: begin
          w_clr_down = w_cur_onehot;
          if (!w_any_below) w_clr_up = w_cur_onehot;
        end
        default: begin
          w_clr_up   = w_cur_onehot;
          w_clr_down = w_cur_onehot;
        end
      endcase
    end
  end

  assign w_car_nxt  = (r_pend_car  | btn_car)       & ~w_clr_car;
  assign w_up_nxt   = (r_pend_up   | btn_hall_up)   & ~w_clr_up   & c_up_mask;
  assign w_down_nxt = (r_pend_down | btn_hall_down) & ~w_clr_down & c_down_mask;

  // Pending-request registers; a clear beats a same-cycle press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pend_car  <= '0;
      r_pend_up   <= '0;
      r_pend_down <= '0;
    end else begin
      r_pend_car  <= w_car_nxt;
      r_pend_up   <= w_up_nxt;
      r_pend_down <= w_down_nxt;
    end
  end

  // Direction, target and valid registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_direction <= DIR_IDLE;
      r_target    <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_direction <= w_dir_nxt;
      r_target    <= w_target_nxt;
      r_valid     <= w_valid_nxt;
    end
  end

  // Next direction: keep sweeping while work remains ahead, otherwise reverse
  // or fall idle. From idle the nearest request wins, ties going up.
  always_comb begin
    w_dir_nxt = r_direction;
    if (w_legal) begin
      case (r_direction)
        DIR_UP: begin
          if (w_up_found)      w_dir_nxt = DIR_UP;
          else if (w_dn_found) w_dir_nxt = DIR_DOWN;
          else                 w_dir_nxt = DIR_IDLE;
        end
        DIR_DOWN: begin
          if (w_dn_found)      w_dir_nxt = DIR_DOWN;
          else if (w_up_found) w_dir_nxt = DIR_UP;
          else                 w_dir_nxt = DIR_IDLE;
        end
        default: begin
          if (w_req_here)
            w_dir_nxt = DIR_IDLE;
          else if (w_up_found && (!w_dn_found || (w_dist_up <= w_dist_dn)))
            w_dir_nxt = DIR_UP;
          else if (w_dn_found)
            w_dir_nxt = DIR_DOWN;
          else
            w_dir_nxt = DIR_IDLE;
        end
      endcase
    end
  end

  // Target for the chosen direction; holds its last value when nothing is
  // pending or the reported floor is out of range.
  always_comb begin
    w_target_nxt = r_target;
    w_valid_nxt  = r_valid;
    if (w_legal) begin
      case (w_dir_nxt)
        DIR_UP: begin
          w_target_nxt = w_up_sweep;
          w_valid_nxt  = 1'b1;
        end
        DIR_DOWN: begin
          w_target_nxt = w_dn_sweep;
          w_valid_nxt  = 1'b1;
        end
        default: begin
          if (w_req_here) begin
            w_target_nxt = current_floor;
            w_valid_nxt  = 1'b1;
          end else begin
            w_valid_nxt  = 1'b0;
          end
        end
      endcase
    end
  end

  assign target_floor = r_target;
  assign target_valid = r_valid;
  assign direction    = r_direction;
  assign pend_car     = r_pend_car;
  assign pend_up      = r_pend_up;
  assign pend_down    = r_pend_down;

endmodule : elevator_request_scheduler
`default_nettype wire

// File: tb/tb_elevator_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_elevator_request_scheduler
// Description : Directed self-checking bench for elevator_request_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_request_scheduler;

  localparam int N = 6;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] btn_car = '0;
  logic [N-1:0] btn_hall_up = '0;
  logic [N-1:0] btn_hall_down = '0;
  logic [W-1:0] current_floor = '0;
  logic         serviced = 1'b0;
  logic [W-1:0] target_floor;
  logic         target_valid;
  logic [1:0]   direction;
  logic [N-1:0] pend_car;
  logic [N-1:0] pend_up;
  logic [N-1:0] pend_down;

  int errors = 0;
  int checks = 0;

  elevator_request_scheduler #(
    .NUM_FLOORS(N),
    .FLOOR_W   (W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_car      (btn_car),
    .btn_hall_up  (btn_hall_up),
    .btn_hall_down(btn_hall_down),
    .current_floor(current_floor),
    .serviced     (serviced),
    .target_floor (target_floor),
    .target_valid (target_valid),
    .direction    (direction),
    .pend_car     (pend_car),
    .pend_up      (pend_up),
    .pend_down    (pend_down)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    btn_car       = '0;
    btn_hall_up   = '0;
    btn_hall_down = '0;
    serviced      = 1'b0;
    tick();
    reset         = 1'b1;
  endtask

  // Directed scenario sequence.
  initial begin
    // Reset with every car button held.
    reset   = 1'b0;
    btn_car = 6'b111111;
    tick();
    tick();
    check("rst_pend_car", 32'(pend_car), 32'h0);
    check("rst_pend_up", 32'(pend_up), 32'h0);
    check("rst_pend_down", 32'(pend_down), 32'h0);
    check("rst_dir", 32'(direction), 32'h0);
    check("rst_target", 32'(target_floor), 32'h0);
    check("rst_valid", 32'(target_valid), 32'h0);
    reset = 1'b1;
    tick();
    check("rel_pend_car", 32'(pend_car), 32'h3f);
    check("rel_valid_lag", 32'(target_valid), 32'h0);
    btn_car = '0;
    tick();
    check("rel_valid", 32'(target_valid), 32'h1);
    check("rel_target_here", 32'(target_floor), 32'h0);
    check("rel_dir_idle", 32'(direction), 32'h0);

    // Idle at 0, car call to 4, then service at 4.
    do_reset();
    current_floor = 3'd0;
    btn_car = 6'b010000;
    tick();
    btn_car = '0;
    check("t2_pend_car", 32'(pend_car), 32'h10);
    check("t2_dir_lag", 32'(direction), 32'h0);
    tick();
    check("t2_dir_up", 32'(direction), 32'h1);
    check("t2_target4", 32'(target_floor), 32'h4);
    check("t2_valid", 32'(target_valid), 32'h1);
    current_floor = 3'd4;
    serviced = 1'b1;
    tick();
    serviced = 1'b0;
    check("t2_cleared", 32'(pend_car), 32'h0);
    tick();
    check("t2_dir_idle", 32'(direction), 32'h0);
    check("t2_valid0", 32'(target_valid), 32'h0);
    check("t2_target_hold", 32'(target_floor), 32'h4);

    // Up sweep from 2: car 5, up 3, down 1.
    do_reset();
    current_floor = 3'd2;
    btn_car       = 6'b100000;
    btn_hall_up   = 6'b001000;
    btn_hall_down = 6'b000010;
    tick();
    btn_car = '0; btn_hall_up = '0; btn_hall_down = '0;
    tick();
    check("t3_dir_up", 32'(direction), 32'h1);
    check("t3_target3", 32'(target_floor), 32'h3);
    current_floor = 3'd3;
    serviced = 1'b1;
    tick();
    serviced = 1'b0;
    check("t3_up_clr", 32'(pend_up), 32'h0);
    check("t3_down_keep", 32'(pend_down), 32'h02);
    check("t3_car_keep", 32'(pend_car), 32'h20);
    tick();
    check("t3_target5", 32'(target_floor), 32'h5);
    check("t3_dir_up2", 32'(direction), 32'h1);
    current_floor = 3'd5;
    serviced = 1'b1;
    tick();
    serviced = 1'b0;
    check("t3_car5_clr", 32'(pend_car), 32'h0);
    tick();
    check("t3_dir_down", 32'(direction), 32'h2);
    check("t3_target1", 32'(target_floor), 32'h1);

    // Up at 3 with only a down call at 4: turnaround clears it.
    do_reset();
    current_floor = 3'd3;
    btn_hall_down = 6'b010000;
    tick();
    btn_hall_down = '0;
    tick();
    check("t4_dir_up", 32'(direction), 32'h1);
    check("t4_target4", 32'(target_floor), 32'h4);
    current_floor = 3'd4;
    serviced = 1'b1;
    tick();
    serviced = 1'b0;
    check("t4_down_clr", 32'(pend_down), 32'h0);
    tick();
    check("t4_dir_idle", 32'(direction), 32'h0);
    check("t4_valid0", 32'(target_valid), 32'h0);

    // Mirror: down at 3 with only an up call at 1.
    do_reset();
    current_floor = 3'd3;
    btn_hall_up = 6'b000010;
    tick();
    btn_hall_up = '0;
    tick();
    check("t4m_dir_down", 32'(direction), 32'h2);
    check("t4m_target1", 32'(target_floor), 32'h1);
    current_floor = 3'd1;
    serviced = 1'b1;
    tick();
    serviced = 1'b0;
    check("t4m_up_clr", 32'(pend_up), 32'h0);

    // Clear beats a same-cycle press at the serviced floor only.
    do_reset();
    current_floor = 3'd2;
    serviced = 1'b1;
    btn_car  = 6'b001100;
    tick();
    serviced = 1'b0;
    btn_car  = '0;
    check("t5_clear_wins", 32'(pend_car), 32'h08);

    // Tie from idle at 2 goes up; ignored hall bits never latch.
    do_reset();
    current_floor = 3'd2;
    btn_car       = 6'b010001;
    btn_hall_up   = 6'b100000;
    btn_hall_down = 6'b000001;
    tick();
    btn_car = '0; btn_hall_up = '0; btn_hall_down = '0;
    check("t6_up_ign", 32'(pend_up), 32'h0);
    check("t6_down_ign", 32'(pend_down), 32'h0);
    check("t6_car", 32'(pend_car), 32'h11);
    tick();
    check("t6_tie_up", 32'(direction), 32'h1);
    check("t6_target4", 32'(target_floor), 32'h4);

    // Out-of-range floor: outputs and requests hold.
    current_floor = 3'd7;
    serviced = 1'b1;
    tick();
    serviced = 1'b0;
    check("ill_pend_hold", 32'(pend_car), 32'h11);
    tick();
    check("ill_dir_hold", 32'(direction), 32'h1);
    check("ill_valid_hold", 32'(target_valid), 32'h1);
    check("ill_target_hold", 32'(target_floor), 32'h4);

    // Idle at 3, calls at 2 and 5: nearer one below wins.
    do_reset();
    current_floor = 3'd3;
    btn_car = 6'b100100;
    tick();
    btn_car = '0;
    tick();
    check("near_dir_down", 32'(direction), 32'h2);
    check("near_target2", 32'(target_floor), 32'h2);

    // Reset mid-sweep drops everything.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_rst_pend", 32'(pend_car), 32'h0);
    check("mid_rst_dir", 32'(direction), 32'h0);
    check("mid_rst_valid", 32'(target_valid), 32'h0);
    check("mid_rst_target", 32'(target_floor), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_elevator_request_scheduler
`default_nettype wire

// File: doc/elevator_request_scheduler.md
Name: elevator_request_scheduler

Overview:
Upstream stage of the elevator car controller FSM. Latches car and hall button presses into pending-request registers and drives button lamps. Runs a collective (SCAN) direction FSM and presents the next target floor, which the car controller consumes as next_floor. Clears requests when the controller reports service, i.e. door opened at a floor.

Parameters:
NUM_FLOORS, 6, number of served floors (0 = ground); legal range 2..8
FLOOR_W, 3, floor index width; must satisfy 2**FLOOR_W >= NUM_FLOORS

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
btn_car  in  NUM_FLOORS  in-car floor buttons, level, bit i = floor i
btn_hall_up  in  NUM_FLOORS  hall up buttons; bit NUM_FLOORS-1 ignored
btn_hall_down  in  NUM_FLOORS  hall down buttons; bit 0 ignored
current_floor  in  FLOOR_W  floor the car is at or passing, from car controller
serviced  in  1  one-cycle strobe: door opened at current_floor
target_floor  out  FLOOR_W  next floor to serve (drives controller next_floor)
target_valid  out  1  a pending request exists and target_floor is meaningful
direction  out  2  sweep direction: 00 IDLE, 01 UP, 10 DOWN
pend_car  out  NUM_FLOORS  pending car requests (lamp drive)
pend_up  out  NUM_FLOORS  pending hall-up requests
pend_down  out  NUM_FLOORS  pending hall-down requests

Behaviour:
- Reset (reset=0 at posedge clk): all pend_* = 0, direction = IDLE, target_floor = 0, target_valid = 0. A reset mid-sweep drops all requests.
- Request latch, every cycle: pend_x <= (pend_x | btn_x) & ~clr_x. Ignored bits (up at top floor, down at ground) always read 0.
- Clear on serviced=1, only for current_floor < NUM_FLOORS:
  - Always clear the car bit.
  - direction UP: clear the up bit; also clear the down bit if no request exists above.
  - direction DOWN: mirror of UP.
  - direction IDLE: clear both hall bits.
  - Same-cycle press at the serviced floor: clear wins. Presses at other floors latch normally.
- Direction FSM, registered, evaluated on post-update pending state. "above" / "below" mean floors strictly above or below current_floor.
  - IDLE: request at current_floor -> stay IDLE, target = current_floor. Else nearest request by absolute distance -> UP or DOWN; tie -> UP. No requests -> IDLE, target_valid = 0.
  - UP: target = lowest floor above with a car or up request. If none, the highest floor above with a down request. If nothing above -> DOWN when any request below, else IDLE.
  - DOWN: symmetric. Target = highest floor below with a car or down request, else the lowest floor below with an up request. If nothing below -> UP when any request above, else IDLE.
- Latency:
  - Button press -> pend_* bit visible next cycle.
  - Pending change -> target_floor, target_valid and direction visible one further cycle later (two cycles from press).
  - serviced -> bit cleared next cycle.
- target_floor holds its last value while target_valid = 0.
- current_floor >= NUM_FLOORS is illegal. Clears are suppressed; target_valid and direction hold.
- Widths: floor compares are unsigned, FLOOR_W bits. Request vectors are exactly NUM_FLOORS bits. No wrap-around.

Decomposition:
- Shared package elevator_pkg:
  - direction typedef (IDLE/UP/DOWN, 2 bits)
  - default NUM_FLOORS and FLOOR_W constants
  - both shared with the car controller so next_floor width matches
- One sub-module: elevator_floor_search (combinational). Inputs: request mask, current_floor, search direction. Outputs: nearest floor above or below, plus a found flag. Instantiated twice: above and below.
- Top-level: request registers, clear logic, FSM.

Test Plan:
- Reset with btn_car=6'b111111 held -> all outputs 0. After release of reset: pend_car=6'b111111 next cycle, target_valid=1 one cycle after that.
- Idle at floor 0, btn_car[4] pulse -> cycle+1 pend_car=6'b010000; cycle+2 direction=UP, target_floor=4. serviced at floor 4 -> pend_car=0, direction=IDLE, target_valid=0.
- Car at 2 going UP, pending car 5, hall_up 3, hall_down 1 -> target 3. After service at 3 -> target 5. After service at 5 -> direction DOWN, target 1.
- UP at floor 3, only hall_down[4] pending -> target 4. serviced at 4 -> down bit cleared (nothing above), direction IDLE.
- Same cycle: serviced at floor 2 and btn_car[2] pressed -> pend_car[2] stays 0. btn_car[3] pressed in the same cycle -> pend_car[3]=1.
- Idle at floor 2 with requests at floors 0 and 4 (tie) -> direction UP, target 4. btn_hall_up[5] and btn_hall_down[0] pressed -> never latched.
